sd_spi_cmd_engine: RTL and testbench
====================================

Name: sd_spi_cmd_engine

Overview:
SPI-mode SD-card command engine. It frames and shifts out one 48-bit SD command, collects the R1 response plus any R3/R7 trailer, and for single-block reads (CMD17) streams the 512 data bytes out one at a time. It sits between host-side control logic (register bank or block-fetch driver) and the card pins. It also provides a programmable SCLK divider and a free-running clock mode for the card's power-up clocking.

Parameters:
RESP_POLLS, 8, maximum bytes polled for an R1 start bit before timeout.
TOKEN_POLLS, 4096, maximum bytes polled for the 0xFE data token before timeout.

Ports:
clk  input  1  system clock (96 MHz nominal).
rst  input  1  reset; asynchronous, active-low (0 = reset).
sclk  output  1  SPI clock to card, idle low.
mosi  output  1  SPI data to card, idle high.
miso  input  1  SPI data from card.
cs  output  1  card chip-select, active low.
cmd  input  7  cmd[5:0] = command index; cmd[6] ignored.
address  input  32  command argument.
en  input  1  start request (level).
en_clk  input  1  free-run SCLK while idle.
div_clk  input  8  SCLK half-period = div_clk+1 clk cycles.
i_cs  input  1  chip-select value driven while idle.
valid_status  output  1  one-clk pulse: transaction finished, resp_status valid.
resp_status  output  7  R1[6:0]; 7'h7F = timeout/none.
rdy  output  1  high in IDLE only.
data_out  output  8  received payload byte.
data_out_valid  output  1  one-clk strobe for data_out.

Behaviour:
- Reset values: sclk 0, mosi 1, cs 1, rdy 1, valid_status 0, data_out_valid 0, resp_status 7'h7F, data_out 0, state IDLE. Reset mid-transaction aborts immediately.
- SPI mode 0, MSB first. Divider counter runs 0..div_clk; on wrap, sclk toggles. mosi changes after the falling edge (first bit set up before the first rising edge). miso is sampled on the rising edge. div_clk is sampled at the start of each half-period.
- IDLE: cs = i_cs, mosi = 1. sclk free-runs if en_clk = 1, otherwise it is held low; when en_clk drops, sclk stops low.
- IDLE -> SEND when en = 1. The clk cycle of that transition latches cmd, address; rdy goes 0 the same cycle and cs goes 0. The divider restarts with sclk low.
- SEND: shift 48 bits: 0, 1, cmd[5:0], address[31:0], CRC7[6:0], 1. CRC7 uses polynomial x^7+x^3+1, init 0, over the first 40 bits.
- RESP: clock bytes with mosi = 1. The first byte with bit7 = 0 is R1. If none within RESP_POLLS bytes: resp_status = 7F, go to TRAIL.
- Index 8 or 58: after R1, read 4 more bytes; each is strobed on data_out/data_out_valid.
- Index 17 with R1 == 0: poll bytes until 0xFE (timeout TOKEN_POLLS -> resp_status = 7F, TRAIL). Then read 512 bytes, each strobed one clk after its 8th rising-edge sample. Then read and discard 2 CRC bytes.
- Index 17 with R1 ≠ 0 skips the data phase.
- TRAIL: 8 additional sclk cycles, cs low, mosi 1.
- DONE: cs = i_cs, sclk low. valid_status pulses one clk on DONE entry, with resp_status updated that same cycle. The engine stays in DONE while en = 1; when en = 0 it returns to IDLE (rdy = 1) next clk. An en held high never retriggers.
- Changes to cmd, address, div_clk or en_clk during a transaction are ignored. The data and R1 counters do not wrap; the 512-byte count is exact.

Test Plan:
- Reset then release, div_clk = 0xD0, en_clk = 1 -> sclk period exactly 418 clk, cs = i_cs, mosi = 1, resp_status = 7F, rdy = 1.
- CMD0, arg 0, card model returns 0x01 on the second poll byte -> MOSI bytes 40 00 00 00 00 95. valid_status single pulse, resp_status = 01. rdy stays 0 until en drops, then 1.
- CMD8, arg 0x1AA, div_clk = 0 -> MOSI 48 00 00 01 AA 87, sclk = clk/2. Response 01 00 00 01 AA -> resp_status 01, four strobes 00 00 01 AA.
- miso stuck 1 on CMD55 -> 8 poll bytes, then 8 trail clocks, resp_status = 7F, valid_status pulses.
- CMD17, arg 0x200: model returns R1 00, FF FF FF, FE, bytes i mod 256 for i = 0..511, CRC 2 bytes -> exactly 512 data_out_valid pulses with matching values, resp_status 00, no strobes for the CRC bytes.
- Assert rst low mid-data-phase -> cs 1, sclk 0, rdy 1 immediately, no further strobes; a subsequent CMD0 completes normally.

Source files
------------

// File: rtl/sd_spi_cmd_engine.sv
// sd_spi_cmd_engine
//   Frames one 48-bit SPI-mode SD command, collects the R1 response (plus the
//   4-byte R3/R7 trailer for CMD8/CMD58) and, for CMD17, streams the 512 data
//   bytes. Also provides a programmable SCLK divider and an idle free-run
//   clock mode used for card power-up clocking.
//
// Ports
//   clk, rst            system clock, async active-low reset
//   sclk, mosi, cs      card pins out (mode 0, MSB first, cs active low)
//   miso                card data in
//   cmd[5:0], address   command index and argument (cmd[6] ignored)
//   en                  start request (level)
//   en_clk              free-run sclk while idle
//   div_clk             sclk half-period = div_clk+1 clk cycles
//   i_cs                chip-select value driven while idle/done
//   valid_status        one-clk pulse when a transaction finishes
//   resp_status         R1[6:0], 7'h7F on timeout
//   rdy                 high only in IDLE
//   data_out(_valid)    received trailer/payload byte strobe
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | cs follows i_cs, optional free-running sclk
// SEND    | shifting out the 48-bit command frame
// RESP    | polling bytes for the R1 start bit
// R7      | reading the 4-byte R3/R7 trailer (strobed)
// TOKEN   | polling for the 0xFE data start token
// DATA    | reading 512 payload bytes (strobed)
// DCRC    | reading and discarding the 2 data CRC bytes
// TRAIL   | 8 extra sclk cycles with cs low, mosi high
// DONE    | status reported, waiting for en to drop

module sd_spi_cmd_engine #(
  parameter int RESP_POLLS  = 8,
  parameter int TOKEN_POLLS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs,
  input  logic [6:0]  cmd,
  input  logic [31:0] address,
  input  logic        en,
  input  logic        en_clk,
  input  logic [7:0]  div_clk,
  input  logic        i_cs,
  output logic        valid_status,
  output logic [6:0]  resp_status,
  output logic        rdy,
  output logic [7:0]  data_out,
  output logic        data_out_valid
);

  localparam int MAXC = (TOKEN_POLLS > RESP_POLLS) ? TOKEN_POLLS : RESP_POLLS;
  localparam int CW   = $clog2((MAXC > 512) ? MAXC : 512) + 1;

  localparam logic [CW-1:0] RESP_LAST  = CW'(RESP_POLLS - 1);
  localparam logic [CW-1:0] TOKEN_LAST = CW'(TOKEN_POLLS - 1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(511);
  localparam logic [CW-1:0] R7_LAST    = CW'(3);
  localparam logic [CW-1:0] CRC_LAST   = CW'(1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_SEND, ST_RESP, ST_R7, ST_TOKEN, ST_DATA, ST_DCRC, ST_TRAIL, ST_DONE
  } state_t;

  state_t          r_state;
  logic            r_sclk;
  logic            r_mosi;
  logic            r_cs;
  logic            r_rdy;
  logic            r_valid;
  logic [6:0]      r_resp;
  logic [6:0]      r_r1;
  logic [7:0]      r_dout;
  logic            r_dov;
  logic [7:0]      r_div_cnt;
  logic [7:0]      r_div_lat;
  logic [5:0]      r_bit_cnt;
  logic [CW-1:0]   r_byte_cnt;
  logic [5:0]      r_idx;
  logic [46:0]     r_tx;
  logic [6:0]      r_rx;

  logic [39:0]     w_frame;
  logic [6:0]      w_crc;
  logic            w_wrap;
  logic            w_rise;
  logic            w_fall;
  logic [7:0]      w_rx_byte;
  logic            w_byte_end;
  logic            w_unused;

  // Bit-serial CRC7, polynomial x^7 + x^3 + 1, init 0.
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    end
    return c;
  endfunction

  assign w_frame    = {2'b01, cmd[5:0], address};
  assign w_crc      = crc7(w_frame);
  assign w_unused   = cmd[6];
  assign w_wrap     = (r_div_cnt == r_div_lat);
  assign w_rise     = w_wrap & ~r_sclk;
  assign w_fall     = w_wrap & r_sclk;
  assign w_rx_byte  = {r_rx, miso};
  assign w_byte_end = (r_bit_cnt == 6'd7);

  assign sclk           = r_sclk;
  assign mosi           = r_mosi;
  assign cs             = r_cs;
  assign rdy            = r_rdy;
  assign valid_status   = r_valid;
  assign resp_status    = r_resp;
  assign data_out       = r_dout;
  assign data_out_valid = r_dov;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b1;
      r_cs       <= 1'b1;
      r_rdy      <= 1'b1;
      r_valid    <= 1'b0;
      r_resp     <= 7'h7F;
      r_r1       <= 7'h7F;
      r_dout     <= 8'h00;
      r_dov      <= 1'b0;
      r_div_cnt  <= 8'h00;
      r_div_lat  <= 8'h00;
      r_bit_cnt  <= 6'd0;
      r_byte_cnt <= '0;
      r_idx      <= 6'd0;
      r_tx       <= '1;
      r_rx       <= 7'h7F;
    end else begin
      r_valid <= 1'b0;
      r_dov   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cs   <= i_cs;
          r_mosi <= 1'b1;
          if (en) begin
            r_state    <= ST_SEND;
            r_rdy      <= 1'b0;
            r_cs       <= 1'b0;
            r_idx      <= cmd[5:0];
            // start bit goes straight to mosi; the remaining 47 bits queue in r_tx
            r_mosi     <= w_frame[39];
            r_tx       <= {w_frame[38:0], w_crc, 1'b1};
            r_sclk     <= 1'b0;
            r_div_cnt  <= 8'h00;
            r_div_lat  <= div_clk;
            r_bit_cnt  <= 6'd0;
            r_byte_cnt <= '0;
            r_r1       <= 7'h7F;
          end else if (en_clk) begin
            if (w_wrap) begin
              r_sclk    <= ~r_sclk;
              r_div_cnt <= 8'h00;
              r_div_lat <= div_clk;
            end else begin
              r_div_cnt <= r_div_cnt + 8'd1;
            end
          end else begin
            r_sclk    <= 1'b0;
            r_div_cnt <= 8'h00;
            r_div_lat <= div_clk;
          end
        end

        ST_DONE: begin
          r_cs   <= i_cs;
          r_sclk <= 1'b0;
          if (!en) begin
            r_state <= ST_IDLE;
            r_rdy   <= 1'b1;
          end
        end

        default: begin
          if (w_wrap) begin
            r_sclk    <= ~r_sclk;
            r_div_cnt <= 8'h00;
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end

          // Falling edge: present next bit; r_tx back-fills with ones so mosi
          // idles high for the whole receive phase.
          if (w_fall) begin
            r_mosi <= r_tx[46];
            r_tx   <= {r_tx[45:0], 1'b1};
            if (r_state == ST_TRAIL && r_bit_cnt == 6'd8) begin
              r_state <= ST_DONE;
              r_valid <= 1'b1;
              r_resp  <= r_r1;
              r_cs    <= i_cs;
            end
          end

          if (w_rise) begin
            r_rx <= w_rx_byte[6:0];
            case (r_state)
              ST_SEND: begin
                if (r_bit_cnt == 6'd47) begin
                  r_state   <= ST_RESP;
                  r_bit_cnt <= 6'd0;
                end else begin
                  r_bit_cnt <= r_bit_cnt + 6'd1;
                end
              end
              ST_TRAIL: r_bit_cnt <= r_bit_cnt + 6'd1;
              default: begin
                r_bit_cnt <= w_byte_end ? 6'd0 : r_bit_cnt + 6'd1;
                if (w_byte_end) begin
                  case (r_state)
                    ST_RESP: begin
                      if (!w_rx_byte[7]) begin
                        r_r1       <= w_rx_byte[6:0];
                        r_byte_cnt <= '0;
                        if (r_idx == 6'd8 || r_idx == 6'd58)
                          r_state <= ST_R7;
                        else if (r_idx == 6'd17 && w_rx_byte == 8'h00)
                          r_state <= ST_TOKEN;
                        else
                          r_state <= ST_TRAIL;
                      end else if (r_byte_cnt == RESP_LAST) begin
                        r_r1    <= 7'h7F;
                        r_state <= ST_TRAIL;
                      end else begin
                        r_byte_cnt <= r_byte_cnt + CW'(1);
                      end
                    end
                    ST_R7: begin
                      r_dout <= w_rx_byte;
                      r_dov  <= 1'b1;
                      if (r_byte_cnt == R7_LAST) r_state <= ST_TRAIL;
                      else r_byte_cnt <= r_byte_cnt + CW'(1);
                    end
                    ST_TOKEN: begin
                      if (w_rx_byte == 8'hFE) begin
                        r_state    <= ST_DATA;
                        r_byte_cnt <= '0;
                      end else if (r_byte_cnt == TOKEN_LAST) begin
                        r_r1    <= 7'h7F;
                        r_state <= ST_TRAIL;
                      end else begin
                        r_byte_cnt <= r_byte_cnt + CW'(1);
                      end
                    end
                    ST_DATA: begin
                      r_dout <= w_rx_byte;
                      r_dov  <= 1'b1;
                      if (r_byte_cnt == DATA_LAST) begin
                        r_state    <= ST_DCRC;
                        r_byte_cnt <= '0;
                      end else begin
                        r_byte_cnt <= r_byte_cnt + CW'(1);
                      end
                    end
                    ST_DCRC: begin
                      if (r_byte_cnt == CRC_LAST) r_state <= ST_TRAIL;
                      else r_byte_cnt <= r_byte_cnt + CW'(1);
                    end
                    default: r_state <= ST_TRAIL;
                  endcase
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Scoreboard bench for sd_spi_cmd_engine: expected MOSI frames, status and
// data bytes are queued when each command is issued; a card model and an
// output monitor pop and compare as the DUT produces them.
module tb_sd_spi_cmd_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk, mosi, cs, rdy, valid_status, data_out_valid;
  logic        miso = 1'b1;
  logic        en = 1'b0, en_clk = 1'b0, i_cs = 1'b1;
  logic [6:0]  cmd = 7'h00;
  logic [6:0]  resp_status;
  logic [31:0] address = 32'h0;
  logic [7:0]  div_clk = 8'h00;
  logic [7:0]  data_out;

  int total = 0, bad = 0;
  int cyc = 0, n_valid = 0, n_strobe = 0, n_rise = 0;

  logic [7:0] exp_mosi[$];
  logic [7:0] exp_data[$];
  logic [7:0] card_q[$];
  logic [6:0] exp_status[$];

  sd_spi_cmd_engine #(.RESP_POLLS(8), .TOKEN_POLLS(4096)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .miso(miso), .cs(cs),
    .cmd(cmd), .address(address), .en(en), .en_clk(en_clk), .div_clk(div_clk),
    .i_cs(i_cs), .valid_status(valid_status), .resp_status(resp_status),
    .rdy(rdy), .data_out(data_out), .data_out_valid(data_out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // CRC7 by polynomial long division of the 40-bit frame times x^7 by 0x89.
  function automatic logic [7:0] crc_byte(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return {r[6:0], 1'b1};
  endfunction

  task automatic push_frame(input logic [5:0] idx, input logic [31:0] a);
    logic [39:0] f;
    f = {2'b01, idx, a};
    for (int b = 4; b >= 0; b--) exp_mosi.push_back(f[b*8 +: 8]);
    exp_mosi.push_back(crc_byte(f));
  endtask

  // Output monitor
  logic prev_sclk = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (data_out_valid) begin
        n_strobe++;
        chk("data_expected", (exp_data.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_data.size() != 0) chk("data_out", 32'(data_out), 32'(exp_data.pop_front()));
      end
      if (valid_status) begin
        n_valid++;
        chk("status_expected", (exp_status.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_status.size() != 0) chk("resp_status", 32'(resp_status), 32'(exp_status.pop_front()));
      end
      if (sclk && !prev_sclk && !cs) n_rise++;
    end
    prev_sclk = sclk;
  end

  // Card model: captures the 48-bit command, then shifts queued bytes (0xFF when empty)
  int          c_bits = 0;
  logic [47:0] c_cmd = '0;
  logic [7:0]  c_byte = 8'hFF;

  always @(posedge sclk) begin
    if (!cs) begin
      if (c_bits < 48) c_cmd = {c_cmd[46:0], mosi};
      c_bits++;
      if (c_bits == 48) begin
        for (int b = 5; b >= 0; b--) begin
          chk("mosi_expected", (exp_mosi.size() != 0) ? 32'd1 : 32'd0, 32'd1);
          if (exp_mosi.size() != 0) chk("mosi_byte", 32'(c_cmd[b*8 +: 8]), 32'(exp_mosi.pop_front()));
        end
      end
    end
  end

  always @(negedge sclk) begin
    int k;
    if (!cs && c_bits >= 48) begin
      k = (c_bits - 48) % 8;
      if (k == 0) c_byte = (card_q.size() != 0) ? card_q.pop_front() : 8'hFF;
      miso = c_byte[7-k];
    end
  end

  always @(posedge cs) begin
    c_bits = 0;
    miso   = 1'b1;
  end

  task automatic wait_rise(output int c);
    logic p;
    p = sclk;
    c = -1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (sclk && !p) begin
        c = cyc;
        break;
      end
      p = sclk;
    end
  endtask

  task automatic run_txn(input logic [6:0] c, input logic [31:0] a, input logic [7:0] dv,
                         input logic [6:0] st, input int rises, input int strobes, input string nm);
    int  nv0, ns0, t1, t2;
    bit  got;
    exp_status.push_back(st);
    n_rise = 0;
    nv0 = n_valid;
    ns0 = n_strobe;
    @(negedge clk);
    cmd = c; address = a; div_clk = dv; en = 1'b1;
    @(negedge clk);
    chk({nm, "_rdy_low"}, 32'(rdy), 32'd0);
    chk({nm, "_cs_low"}, 32'(cs), 32'd0);
    // changes after launch must not affect the transaction
    cmd = ~c; address = ~a; div_clk = 8'hFF; en_clk = 1'b1;
    if (dv == 8'h00) begin
      wait_rise(t1);
      wait_rise(t2);
      chk({nm, "_sclk_period"}, 32'(t2 - t1), 32'd2);
    end
    got = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (n_valid != nv0) begin
        got = 1'b1;
        break;
      end
    end
    chk({nm, "_completed"}, 32'(got), 32'd1);
    repeat (6) @(negedge clk);
    chk({nm, "_valid_pulses"}, 32'(n_valid - nv0), 32'd1);
    chk({nm, "_rdy_held_low"}, 32'(rdy), 32'd0);
    chk({nm, "_cs_done"}, 32'(cs), 32'd1);
    chk({nm, "_sclk_done"}, 32'(sclk), 32'd0);
    chk({nm, "_rises"}, 32'(n_rise), 32'(rises));
    chk({nm, "_strobes"}, 32'(n_strobe - ns0), 32'(strobes));
    en = 1'b0; en_clk = 1'b0;
    repeat (2) @(negedge clk);
    chk({nm, "_rdy_back"}, 32'(rdy), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, ns0;
    bit hit;
    en_clk = 1'b1; div_clk = 8'hD0; i_cs = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd1);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_valid", 32'(valid_status), 32'd0);
    chk("rst_dov", 32'(data_out_valid), 32'd0);
    chk("rst_resp", 32'(resp_status), 32'h7F);
    chk("rst_data", 32'(data_out), 32'h00);
    rst = 1'b1;

    wait_rise(t1);
    wait_rise(t2);
    chk("idle_period", 32'(t2 - t1), 32'd418);
    chk("idle_cs", 32'(cs), 32'd1);
    chk("idle_mosi", 32'(mosi), 32'd1);
    chk("idle_resp", 32'(resp_status), 32'h7F);
    chk("idle_rdy", 32'(rdy), 32'd1);
    i_cs = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_cs_follow", 32'(cs), 32'd0);
    i_cs = 1'b1;
    wait_rise(t1);
    en_clk = 1'b0;
    repeat (2) @(negedge clk);
    chk("sclk_stops_low", 32'(sclk), 32'd0);

    // CMD0: R1 0x01 on second poll byte
    exp_mosi = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
    card_q   = '{8'hFF, 8'h01};
    run_txn(7'h00, 32'h0, 8'd1, 7'h01, 72, 0, "cmd0");

    // CMD8 with cmd[6] set, R7 trailer, sclk = clk/2
    exp_mosi = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87};
    card_q   = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
    exp_data = '{8'h00, 8'h00, 8'h01, 8'hAA};
    run_txn(7'h48, 32'h1AA, 8'd0, 7'h01, 96, 4, "cmd8");

    // CMD55 with miso stuck high: 8 poll bytes then timeout
    push_frame(6'd55, 32'h0);
    card_q.delete();
    run_txn(7'h37, 32'h0, 8'd1, 7'h7F, 120, 0, "cmd55");

    // CMD17 single block read
    push_frame(6'd17, 32'h200);
    card_q = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
    for (int i = 0; i < 512; i++) begin
      card_q.push_back(8'(i));
      exp_data.push_back(8'(i));
    end
    card_q.push_back(8'h12);
    card_q.push_back(8'h34);
    run_txn(7'h11, 32'h200, 8'd0, 7'h00, 4208, 512, "cmd17");

    // CMD17 aborted by reset during the data phase
    push_frame(6'd17, 32'h200);
    card_q = '{8'h00, 8'hFE};
    for (int i = 0; i < 512; i++) begin
      card_q.push_back(8'(i));
      exp_data.push_back(8'(i));
    end
    exp_status.push_back(7'h00);
    ns0 = n_strobe;
    @(negedge clk);
    cmd = 7'h11; address = 32'h200; div_clk = 8'd0; en = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (n_strobe - ns0 >= 100) begin
        hit = 1'b1;
        break;
      end
    end
    chk("abort_reached_data", 32'(hit), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_cs", 32'(cs), 32'd1);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_rdy", 32'(rdy), 32'd1);
    exp_data.delete();
    exp_status.delete();
    card_q.delete();
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ns0 = n_strobe;
    repeat (300) @(negedge clk);
    chk("abort_no_strobes", 32'(n_strobe - ns0), 32'd0);
    chk("abort_idle_rdy", 32'(rdy), 32'd1);

    exp_mosi = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
    card_q   = '{8'hFF, 8'h01};
    run_txn(7'h00, 32'h0, 8'd1, 7'h01, 72, 0, "cmd0_after_rst");

    chk("mosi_queue_drained", 32'(exp_mosi.size()), 32'd0);
    chk("data_queue_drained", 32'(exp_data.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
